pri_encoder_iter: RTL and testbench

Iterative multi-hit priority encoder. Accepts one masked request vector per transaction and emits the index of every set bit, one per output beat, in priority order. Replaces single-shot encoding wherever all hits need service, not only the winner (interrupt/event scan, free-slot enumeration). Input and output use valid/ready handshakes so it sits directly between pipelined producers and consumers.

---
 rtl/pri_encoder_iter.sv | 117 +++++++++++
 tb/tb_pri_encoder_iter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pri_encoder_iter.sv
// Iterative multi-hit priority encoder. It captures one qualified request vector and
// emits every set index, one per output beat, in priority order.
module pri_encoder_iter #(
   parameter int DWIDTH    = 16,
   parameter bit MSB_FIRST = 1'b1,
   localparam int AW       = $clog2(DWIDTH),
   localparam int CW       = $clog2(DWIDTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] din,
   input  logic [DWIDTH-1:0] din_v,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW-1:0]     dout,
   output logic              dout_last,
   output logic [CW-1:0]     hit_cnt,
   output logic              zero_hit
);

   // state  | meaning
   // S_IDLE | waiting for a request vector; in_ready high
   // S_RUN  | pending holds unserved hits; one index presented per beat
   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] pending_q, pending_d;
   logic [CW-1:0]     hit_cnt_q, hit_cnt_d;
   logic              zero_hit_q, zero_hit_d;

   logic [DWIDTH-1:0] eff;
   logic [CW-1:0]     eff_cnt;
   logic [AW-1:0]     sel_idx;
   logic              one_left;
   logic              run;

   assign eff = din & din_v;

   always_comb begin
      eff_cnt = '0;
      for (int i = 0; i < DWIDTH; i++) begin
         eff_cnt = eff_cnt + CW'(eff[i]);
      end
   end

   // The scan direction decides which hit wins: the last match in the loop overwrites earlier ones.
   always_comb begin
      sel_idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < DWIDTH; i++) begin
            if (pending_q[i]) sel_idx = AW'(i);
         end
      end else begin
         for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = AW'(i);
         end
      end
   end

   assign one_left = (pending_q != '0) && ((pending_q & (pending_q - DWIDTH'(1))) == '0);

   assign run       = (state_q == S_RUN) && !rst;
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = run;
   assign dout      = run ? sel_idx : '0;
   assign dout_last = run && one_left;
   assign hit_cnt   = hit_cnt_q;
   assign zero_hit  = zero_hit_q;

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      hit_cnt_d  = hit_cnt_q;
      zero_hit_d = 1'b0;
      if (flush) begin
         // Flush beats both acceptance and the remaining beats. A beat sampled on this edge still counts as delivered.
         state_d   = S_IDLE;
         pending_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  pending_d  = eff;
                  hit_cnt_d  = eff_cnt;
                  zero_hit_d = (eff == '0);
                  state_d    = (eff == '0) ? S_IDLE : S_RUN;
               end
            end
            S_RUN: begin
               if (out_ready) begin
                  pending_d = pending_q & ~(DWIDTH'(1) << sel_idx);
                  if (one_left) state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         hit_cnt_q  <= '0;
         zero_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         hit_cnt_q  <= hit_cnt_d;
         zero_hit_q <= zero_hit_d;
      end
   end

endmodule

// File: tb/tb_pri_encoder_iter.sv
// Bench for pri_encoder_iter. Three configurations share one stimulus stream:
// 16-bit MSB-first, 16-bit LSB-first and 8-bit LSB-first. Each has its own scoreboard queue.
module tb_pri_encoder_iter;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [15:0] din, din_v;

   logic       u0_ir, u0_ov, u0_last, u0_zh;
   logic [3:0] u0_dout;
   logic [4:0] u0_cnt;
   logic       u1_ir, u1_ov, u1_last, u1_zh;
   logic [3:0] u1_dout;
   logic [4:0] u1_cnt;
   logic       u2_ir, u2_ov, u2_last, u2_zh;
   logic [2:0] u2_dout;
   logic [3:0] u2_cnt;

   int q0[$], q1[$], q2[$];
   int n_cmp = 0;
   int n_err = 0;
   bit rand_bp = 1'b0;

   always #5 clk = ~clk;

   pri_encoder_iter #(.DWIDTH(16), .MSB_FIRST(1'b1)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u0_ir),
      .din(din), .din_v(din_v), .out_valid(u0_ov), .out_ready(out_ready),
      .dout(u0_dout), .dout_last(u0_last), .hit_cnt(u0_cnt), .zero_hit(u0_zh));

   pri_encoder_iter #(.DWIDTH(16), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u1_ir),
      .din(din), .din_v(din_v), .out_valid(u1_ov), .out_ready(out_ready),
      .dout(u1_dout), .dout_last(u1_last), .hit_cnt(u1_cnt), .zero_hit(u1_zh));

   pri_encoder_iter #(.DWIDTH(8), .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u2_ir),
      .din(din[7:0]), .din_v(din_v[7:0]), .out_valid(u2_ov), .out_ready(out_ready),
      .dout(u2_dout), .dout_last(u2_last), .hit_cnt(u2_cnt), .zero_hit(u2_zh));

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected beats are encoded as index + 256 * last.
   task automatic push_model(input logic [15:0] eff);
      int n, k;
      n = $countones(eff); k = 0;
      for (int i = 15; i >= 0; i--)
         if (eff[i]) begin k++; q0.push_back(i + ((k == n) ? 256 : 0)); end
      k = 0;
      for (int i = 0; i < 16; i++)
         if (eff[i]) begin k++; q1.push_back(i + ((k == n) ? 256 : 0)); end
      n = $countones(eff[7:0]); k = 0;
      for (int i = 0; i < 8; i++)
         if (eff[i]) begin k++; q2.push_back(i + ((k == n) ? 256 : 0)); end
   endtask

   always @(negedge clk) begin
      if (u0_ov && out_ready) begin
         if (q0.size() == 0) chk("u0_extra_beat", int'(u0_dout), -1);
         else chk("u0_beat", int'(u0_dout) + (u0_last ? 256 : 0), q0.pop_front());
      end
      if (u1_ov && out_ready) begin
         if (q1.size() == 0) chk("u1_extra_beat", int'(u1_dout), -1);
         else chk("u1_beat", int'(u1_dout) + (u1_last ? 256 : 0), q1.pop_front());
      end
      if (u2_ov && out_ready) begin
         if (q2.size() == 0) chk("u2_extra_beat", int'(u2_dout), -1);
         else chk("u2_beat", int'(u2_dout) + (u2_last ? 256 : 0), q2.pop_front());
      end
      if (rst || flush) begin
         q0.delete(); q1.delete(); q2.delete();
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [15:0] d, input logic [15:0] v);
      int t = 0;
      while (!(u0_ir && u1_ir && u2_ir) && t < 200) begin step(); t++; end
      if (t >= 200) chk("ready_timeout", 0, 1);
      din = d; din_v = v; in_valid = 1'b1;
      push_model(d & v);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(u0_ir && u1_ir && u2_ir && q0.size() == 0 && q1.size() == 0 && q2.size() == 0)
             && t < 300) begin
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
         step(); t++;
      end
      out_ready = 1'b1;
      if (t >= 300) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rd, rv;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0; din_v = '0;
      step(); step(); step();
      chk("rst_in_ready", u0_ir, 0);
      chk("rst_out_valid", u0_ov, 0);
      chk("rst_dout", u0_dout, 0);
      chk("rst_last", u0_last, 0);
      chk("rst_zero_hit", u0_zh, 0);
      rst = 1'b0;
      step();
      chk("rst_hit_cnt", u0_cnt, 0);
      chk("idle_in_ready", u0_ir, 1);

      // 1: basic MSB-first ordering and timing
      send(16'h8421, 16'hFFFF);
      chk("t1_ov", u0_ov, 1); chk("t1_d15", u0_dout, 15); chk("t1_cnt", u0_cnt, 4);
      chk("t1_ir_busy", u0_ir, 0); chk("t1_last0", u0_last, 0);
      step(); chk("t1_d10", u0_dout, 10);
      step(); chk("t1_d5", u0_dout, 5);
      step(); chk("t1_d0", u0_dout, 0); chk("t1_last", u0_last, 1);
      step(); chk("t1_ir_back", u0_ir, 1); chk("t1_ov_off", u0_ov, 0);
      wait_idle();

      // 2: per-bit qualifier
      send(16'h00FF, 16'h0F0F);
      chk("t2_cnt", u0_cnt, 4);
      wait_idle();

      // 3: empty effective vector
      send(16'hFFFF, 16'h0000);
      chk("t3_zh", u0_zh, 1); chk("t3_zh_u2", u2_zh, 1);
      chk("t3_ov", u0_ov, 0); chk("t3_ir", u0_ir, 1); chk("t3_cnt", u0_cnt, 0);
      step();
      chk("t3_zh_pulse", u0_zh, 0); chk("t3_ov2", u0_ov, 0);
      wait_idle();

      // 4: backpressure holds the beat
      out_ready = 1'b0;
      send(16'h0003, 16'hFFFF);
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_ov", u0_ov, 1); chk("t4_hold_d", u0_dout, 1); chk("t4_hold_last", u0_last, 0);
         if (i < 2) step();
      end
      out_ready = 1'b1;
      wait_idle();

      // 5a: flush on second beat
      send(16'h8421, 16'hFFFF);
      step();
      chk("t5_d10", u0_dout, 10);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t5_ov_off", u0_ov, 0); chk("t5_ir", u0_ir, 1); chk("t5_cnt_kept", u0_cnt, 4);
      wait_idle();

      // 5b: reset on second beat
      send(16'h8421, 16'hFFFF);
      step();
      rst = 1'b1;
      #1;
      chk("t5r_ov", u0_ov, 0); chk("t5r_ir", u0_ir, 0); chk("t5r_d", u0_dout, 0); chk("t5r_last", u0_last, 0);
      step();
      rst = 1'b0;
      #1;
      chk("t5r_cnt", u0_cnt, 0); chk("t5r_ov2", u0_ov, 0); chk("t5r_ir2", u0_ir, 1);
      wait_idle();

      // 6: LSB-first and the full 8-bit vector
      send(16'h8421, 16'hFFFF);
      chk("t6_u1_first", u1_dout, 0);
      wait_idle();
      send(16'h00FF, 16'hFFFF);
      chk("t6_u2_cnt", u2_cnt, 8);
      wait_idle();
      send(16'hFFFF, 16'hFFFF);
      chk("t6_u0_cnt16", u0_cnt, 16);
      wait_idle();

      // random vectors with random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rd = 16'($urandom); rv = 16'($urandom);
         send(rd, rv);
         chk("rnd_cnt", u0_cnt, $countones(rd & rv));
         wait_idle();
      end
      rand_bp = 1'b0;

      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      chk("drain_q2", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
